// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_if
//  Description : Instruction-memory request/acknowledge bundle between the
//                instruction-fetch stage (master) and instruction memory
//                (slave). The request is held until the one-cycle ack, and
//                read data is valid in the ack cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_if;
    logic        imem_req;    // fetch request, held high until ack
    logic [31:0] imem_addr;   // word address, stable while imem_req is high
    logic        imem_ack;    // one-cycle acknowledge
    logic [31:0] imem_rdata;  // fetched word, valid with imem_ack

    // Fetch-stage side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Instruction-memory side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : Instruction-fetch stage of the 5-stage MIPS pipeline. Owns
//                the PC, issues req/ack fetches to instruction memory and
//                buffers one fetched word for the IF/ID latch. Honours
//                stall/breakpoint holds and branch/jump redirects, dropping
//                the data of a fetch that a redirect has made stale.
//                Optional build macro: IF_PERF_CNT_EN adds the fetch_cnt and
//                redirect_cnt performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,

    // Hazard / debug holds (shared with the IF/ID latch)
    input  wire logic        stall,
    input  wire logic        breakpoint,

    // Redirects
    input  wire logic        branch_taken,
    input  wire logic [31:0] branch_target,
    input  wire logic        jump,
    input  wire logic [31:0] jump_target,

    // Instruction-memory handshake
    if_fetch_if.master       imem,

    // To the IF/ID latch
    output logic      [31:0] pc_plus4,
    output logic      [31:0] ins_out,
    output logic             clean_n,
    output logic             fetch_busy
`ifdef IF_PERF_CNT_EN
    ,
    output logic      [31:0] fetch_cnt,
    output logic      [31:0] redirect_cnt
`endif
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,   // request outstanding, data will be kept
        S_FULL  = 2'd1,   // one word buffered, no request outstanding
        S_DROP  = 2'd2    // request outstanding, data is stale and discarded
    } state_t;

    localparam logic [31:0] c_PC_STEP = 32'd4;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [31:0] r_pc;           // address of the fetch in progress / next
    logic [31:0] r_buf_pc;       // PC of the buffered word
    logic [31:0] r_ins_buf;      // buffered instruction word
    logic        r_buf_valid;    // buffer holds a live instruction
    logic [31:0] r_redirect_pc;  // pending target while a stale fetch drains

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_consume;

    // A branch resolves in EX and is older than a jump in ID, so it wins.
    assign w_redirect = branch_taken | jump;
    assign w_target   = branch_taken ? branch_target : jump_target;

    // The IF/ID latch captures the buffer on any edge where it is not held.
    assign w_consume  = r_buf_valid & ~stall & ~breakpoint;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Request is forced low while reset is asserted even though the state
    // register already reads S_FETCH.
    assign imem.imem_req  = rst_n & (r_state != S_FULL);
    assign imem.imem_addr = r_pc;

    // Wraps modulo 2^32 naturally.
    assign pc_plus4   = r_buf_pc + c_PC_STEP;
    assign ins_out    = r_buf_valid ? r_ins_buf : NOP_INSN;
    assign clean_n    = ~w_redirect;
    assign fetch_busy = ~r_buf_valid;

    // ------------------------------------------------------------------------
    // Fetch FSM with PC and single-entry instruction buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_buf_pc      <= RESET_PC;
            r_ins_buf     <= NOP_INSN;
            r_buf_valid   <= 1'b0;
            r_redirect_pc <= RESET_PC;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        if (w_redirect) begin
                            // Word belongs to the wrong path: refetch at target.
                            r_pc <= w_target;
                        end else begin
                            r_ins_buf   <= imem.imem_rdata;
                            r_buf_pc    <= r_pc;
                            r_buf_valid <= 1'b1;
                            r_state     <= S_FULL;
                        end
                    end else if (w_redirect) begin
                        // Address must stay stable until the ack, so park the
                        // target and let the stale request drain.
                        r_redirect_pc <= w_target;
                        r_state       <= S_DROP;
                    end
                end

                S_FULL: begin
                    if (w_redirect) begin
                        r_buf_valid <= 1'b0;
                        r_pc        <= w_target;
                        r_state     <= S_FETCH;
                    end else if (w_consume) begin
                        r_buf_valid <= 1'b0;
                        r_pc        <= r_buf_pc + c_PC_STEP;
                        r_state     <= S_FETCH;
                    end
                end

                S_DROP: begin
                    if (imem.imem_ack) begin
                        // Stale data is discarded; the newest target wins.
                        r_pc    <= w_redirect ? w_target : r_redirect_pc;
                        r_state <= S_FETCH;
                    end else if (w_redirect) begin
                        r_redirect_pc <= w_target;
                    end
                end

                default: begin
                    r_buf_valid <= 1'b0;
                    r_state     <= S_FETCH;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_redirect_cnt;

    // Count delivered instructions and redirect cycles; both wrap at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt    <= 32'd0;
            r_redirect_cnt <= 32'd0;
        end else begin
            if (w_consume) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_redirect) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt    = r_fetch_cnt;
    assign redirect_cnt = r_redirect_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline latch in the 5-stage MIPS CPU.
- Owns the PC, issues req/ack fetches to instruction memory, and buffers one fetched word.
- Presents pc_plus4/ins_out to the IF/ID latch and honours the stall, breakpoint and branch/jump redirects that the latch also sees.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSN, 32'h0000_0000, word driven on ins_out when no valid instruction is buffered (sll $0,$0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  load-use stall from hazard unit; same signal that drives the IF/ID latch.
- breakpoint  in  1  debug halt; same signal that drives the IF/ID latch.
- branch_taken  in  1  EX-stage branch resolved taken.
- branch_target  in  32  branch destination.
- jump  in  1  ID-stage jump.
- jump_target  in  32  jump destination.
- imem_req  out  1  fetch request, held high until ack.
- imem_addr  out  32  word address; stable while imem_req is high.
- imem_ack  in  1  one-cycle acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched word.
- pc_plus4  out  32  buffered PC + 4, to IF/ID.
- ins_out  out  32  buffered instruction, or NOP_INSN; to IF/ID.
- clean_n  out  1  active-low IF/ID flush; combinational, equal to ~(branch_taken | jump).
- fetch_busy  out  1  high whenever buf_valid = 0 (debug/perf visibility).

Behaviour:
- Registers: pc, buf_pc, ins_buf, buf_valid, redirect_pc, state.
- States: S_FETCH, S_FULL, S_DROP.
- consume = buf_valid & ~stall & ~breakpoint. At that edge the IF/ID latch captures the buffer.
- redirect = branch_taken | jump. Target is branch_target if branch_taken is high, else jump_target. Branch wins over a simultaneous jump because it is the older instruction.
- Reset (async, any state, mid-request included):
  - pc = RESET_PC, state = S_FETCH, buf_valid = 0.
  - ins_out = NOP_INSN, pc_plus4 = RESET_PC + 4, imem_req = 0 while rst_n is low.
  - Any in-flight ack is abandoned; imem must tolerate this.
- S_FETCH:
  - imem_req = 1, imem_addr = pc.
  - ack & ~redirect: ins_buf <= imem_rdata, buf_pc <= pc, buf_valid <= 1, go to S_FULL.
  - ack & redirect: data discarded, pc <= target, stay in S_FETCH. A new request goes out next cycle with the new address.
  - ~ack & redirect: redirect_pc <= target, go to S_DROP. The request stays high with the old address.
- S_FULL:
  - imem_req = 0.
  - redirect (priority over consume): buf_valid <= 0, pc <= target, go to S_FETCH.
  - consume: buf_valid <= 0, pc <= buf_pc + 4, go to S_FETCH.
  - Otherwise hold everything. Stall and breakpoint hold indefinitely.
- S_DROP:
  - imem_req = 1, imem_addr = pc (old address).
  - redirect: redirect_pc <= new target; the latest redirect wins.
  - ack: data discarded. pc <= redirect_pc, or the same-cycle target if redirect is also high. Go to S_FETCH.
- Outputs:
  - ins_out = buf_valid ? ins_buf : NOP_INSN.
  - pc_plus4 = buf_pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - While buf_valid = 0 the IF/ID latch captures NOP bubbles.
- Breakpoint has exactly the same effect as stall in this stage. Redirects are still accepted during stall or breakpoint.
- Throughput: 1 instruction per 2 cycles with single-cycle ack (no prefetch overlap).

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, adds two outputs:
  - fetch_cnt (32): increments on each consume.
  - redirect_cnt (32): increments on each cycle with redirect high.
  - Both reset to 0 and wrap at 2^32.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_ack every request cycle, no stall: imem_addr sequence 0,4,8. ins_out/pc_plus4 show each word with pc_plus4 = 4,8,12, each valid for 1 cycle, alternating with NOP.
- Buffer full at buf_pc = 8, stall high 3 cycles: ins_out and pc_plus4 = 12 held; imem_req = 0; 8 consumed on the first cycle with stall low.
- Request at 0x10 outstanding, branch_taken with branch_target = 0x40 and no ack; ack arrives 2 cycles later: that data is dropped, next imem_addr = 0x40, clean_n low only in the branch cycle.
- branch_taken (target 0x80) and jump (target 0xC0) in the same cycle: next fetch address 0x80.
- rst_n pulled low while in S_DROP: outputs return to NOP / RESET_PC + 4 immediately; after release the first imem_addr = RESET_PC.
- With IF_PERF_CNT_EN: 5 consumes and 2 redirects give fetch_cnt = 5, redirect_cnt = 2.
